// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and memory-side bus of the load/store unit
//
// Purpose: groups the execute-stage request handshake, the response handshake
// and the single-port memory connection into one bundle.
// Modports:
//   slave  - the load/store unit (takes requests, drives memory outputs)
//   master - the environment (execute stage, response consumer, memory)
interface load_store_unit_if #(
  parameter int ADDR_BITS = 14
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [2:0]           req_funct3;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [31:0]          resp_rdata;
  logic                 resp_fault;
  logic [3:0]           mem_write_mask;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [31:0]          mem_write_data;
  logic [31:0]          mem_read_data;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_write_mask, mem_addr, mem_write_data
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    output resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_write_mask, mem_addr, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32E byte-addressed load/store front end for a 32-bit word memory
//
// Purpose: turns one load/store request into a word address, lane-aligned
// write data and byte mask, then returns formatted load data or a fault.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - load_store_unit_if.slave: req_* handshake in, resp_* handshake
//           out, mem_* to/from the synchronous single-port memory
module load_store_unit #(
  parameter int ADDR_BITS = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  load_store_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } state_t;

  state_t               state_q;
  logic                 req_ready_q;
  logic                 resp_valid_q;
  logic                 resp_fault_q;
  logic [31:0]          resp_rdata_q;
  logic [3:0]           mem_write_mask_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic [31:0]          mem_write_data_q;
  logic                 write_q;
  logic [2:0]           funct3_q;
  logic [1:0]           off_q;

  // Request decode (only meaningful while idle)
  logic [1:0]  req_off_d;
  logic        misaligned_d;
  logic        out_of_range_d;
  logic        illegal_d;
  logic        fault_d;
  logic [31:0] lane_data_d;
  logic [3:0]  lane_mask_d;

  assign req_off_d = bus.req_addr[1:0];

  always_comb begin
    misaligned_d   = 1'b0;
    out_of_range_d = |bus.req_addr[31:ADDR_BITS+2];
    illegal_d      = 1'b0;
    // funct3[1:0] is the access size for every legal encoding
    if (bus.req_funct3[1:0] == 2'b01) begin
      misaligned_d = req_off_d[0];
    end else if (bus.req_funct3[1:0] == 2'b10) begin
      misaligned_d = (req_off_d != 2'b00);
    end
    if (bus.req_write) begin
      illegal_d = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
    end else begin
      illegal_d = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                  (bus.req_funct3 == 3'b111);
    end
    fault_d = misaligned_d || out_of_range_d || illegal_d;
  end

  // Store data is replicated across lanes so the mask alone selects the bytes
  always_comb begin
    lane_data_d = bus.req_wdata;
    lane_mask_d = 4'b1111;
    case (bus.req_funct3[1:0])
      2'b00: begin
        lane_data_d = {4{bus.req_wdata[7:0]}};
        lane_mask_d = 4'b0001 << req_off_d;
      end
      2'b01: begin
        lane_data_d = {2{bus.req_wdata[15:0]}};
        lane_mask_d = 4'b0011 << req_off_d;
      end
      default: begin
        lane_data_d = bus.req_wdata;
        lane_mask_d = 4'b1111;
      end
    endcase
  end

  // Load formatting from the captured offset and funct3
  logic [31:0] rd_shift_d;
  logic [7:0]  rd_byte_d;
  logic [15:0] rd_half_d;
  logic [31:0] load_fmt_d;

  always_comb begin
    rd_shift_d = bus.mem_read_data >> {off_q, 3'b000};
    rd_byte_d  = rd_shift_d[7:0];
    rd_half_d  = off_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
    case (funct3_q)
      3'b000:  load_fmt_d = {{24{rd_byte_d[7]}}, rd_byte_d};
      3'b001:  load_fmt_d = {{16{rd_half_d[15]}}, rd_half_d};
      3'b010:  load_fmt_d = bus.mem_read_data;
      3'b100:  load_fmt_d = {24'h000000, rd_byte_d};
      3'b101:  load_fmt_d = {16'h0000, rd_half_d};
      default: load_fmt_d = 32'h0000_0000;
    endcase
  end

  // Control FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      req_ready_q      <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_fault_q     <= 1'b0;
      resp_rdata_q     <= 32'h0000_0000;
      mem_write_mask_q <= 4'b0000;
      mem_addr_q       <= '0;
      mem_write_data_q <= 32'h0000_0000;
      write_q          <= 1'b0;
      funct3_q         <= 3'b000;
      off_q            <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_ready_q && bus.req_valid) begin
            req_ready_q  <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            if (fault_d) begin
              // Faults skip the memory entirely, so the mask stays zero
              resp_fault_q <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              resp_fault_q <= 1'b0;
              mem_addr_q   <= bus.req_addr[ADDR_BITS+1:2];
              write_q      <= bus.req_write;
              funct3_q     <= bus.req_funct3;
              off_q        <= req_off_d;
              if (bus.req_write) begin
                mem_write_data_q <= lane_data_d;
                mem_write_mask_q <= lane_mask_d;
              end
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // Memory samples address/mask at the end of this cycle
          mem_write_mask_q <= 4'b0000;
          if (write_q) begin
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          resp_rdata_q <= load_fmt_d;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.resp_fault     = resp_fault_q;
  assign bus.mem_write_mask = mem_write_mask_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = mem_write_data_q;

endmodule
